// File: rtl/alu_pkg.sv
// Shared ALU opcodes, mul/div FSM encoding and datapath width.
package alu_pkg;

    localparam int WIDTH = 32;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_MFHI  = 4'b0011;
    localparam logic [3:0] ALU_MFLO  = 4'b0100;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_LUI   = 4'b1000;
    localparam logic [3:0] ALU_MULT  = 4'b1011;
    localparam logic [3:0] ALU_MULTU = 4'b1100;
    localparam logic [3:0] ALU_DIV   = 4'b1101;
    localparam logic [3:0] ALU_DIVU  = 4'b1110;

    // Counter value during the final iterative step.
    localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    function automatic logic is_muldiv(input logic [3:0] code);
        return (code == ALU_MULT) || (code == ALU_MULTU) ||
               (code == ALU_DIV)  || (code == ALU_DIVU);
    endfunction

endpackage

// File: rtl/md_iter.sv
// Iterative 32-step multiply / restoring divide on operand magnitudes,
// with sign fixup applied to the HI:LO output while in DONE.
module md_iter
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   hilo
);

    md_state_t state_reg, state_next;
    logic [5:0]           cnt_reg;
    logic                 is_div_reg, neg_q_reg, neg_r_reg;
    logic [WIDTH-1:0]     mag_a_reg, mag_b_reg;
    logic [2*WIDTH-1:0]   acc_reg;

    logic                 op_signed, op_div, sign_a, sign_b;
    logic [WIDTH:0]       mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0]   mul_next, div_next;

    assign op_signed = (op == ALU_MULT) || (op == ALU_DIV);
    assign op_div    = (op == ALU_DIV)  || (op == ALU_DIVU);
    assign sign_a    = op_signed & a[WIDTH-1];
    assign sign_b    = op_signed & b[WIDTH-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (cnt_reg == LAST_STEP) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        done = (state_reg == ST_DONE);
    end

    // Multiply: low half holds the multiplier, shifted out as the product
    // accumulates in the high half. Divide: high half is the partial
    // remainder, low half shifts the dividend out and quotient bits in.
    assign mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, mag_a_reg} : '0);
    assign mul_next  = {mul_sum, acc_reg[WIDTH-1:1]};
    assign div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, mag_b_reg};
    assign div_next  = div_diff[WIDTH] ? {acc_reg[2*WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg    <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            mag_a_reg  <= '0;
            mag_b_reg  <= '0;
            acc_reg    <= '0;
        end else if (state_reg == ST_IDLE) begin
            if (start) begin
                cnt_reg    <= '0;
                is_div_reg <= op_div;
                neg_q_reg  <= sign_a ^ sign_b;
                neg_r_reg  <= sign_a;
                mag_a_reg  <= sign_a ? -a : a;
                mag_b_reg  <= sign_b ? -b : b;
                acc_reg    <= {{WIDTH{1'b0}}, (op_div ? (sign_a ? -a : a) : (sign_b ? -b : b))};
            end
        end else if (state_reg == ST_RUN) begin
            cnt_reg <= cnt_reg + 6'd1;
            acc_reg <= is_div_reg ? div_next : mul_next;
        end
    end

    always_comb begin
        hilo = neg_q_reg ? -acc_reg : acc_reg;
        if (is_div_reg) begin
            if (mag_b_reg == '0) begin
                // Recover the operand as originally presented.
                hilo = {(neg_r_reg ? -mag_a_reg : mag_a_reg), {WIDTH{1'b1}}};
            end else begin
                hilo[WIDTH-1:0]       = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
                hilo[2*WIDTH-1:WIDTH] = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH]
                                                  : acc_reg[2*WIDTH-1:WIDTH];
            end
        end
    end

endmodule

// File: rtl/alu_md.sv
// Execute-stage ALU: combinational operations plus HI/LO registers fed by
// the iterative mul/div unit, which stalls the pipeline while it runs.
module alu_md
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       alu_control,
    input  logic             valid,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             stall
);

    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               is_md, md_done;
    logic [2*WIDTH-1:0] md_hilo;

    assign is_md = is_muldiv(alu_control);

    md_iter u_md_iter (
        .clk   (clk),
        .reset (reset),
        .start (valid & is_md),
        .op    (alu_control),
        .a     (src_a),
        .b     (src_b),
        .done  (md_done),
        .hilo  (md_hilo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (md_done) begin
            hi_reg <= md_hilo[2*WIDTH-1:WIDTH];
            lo_reg <= md_hilo[WIDTH-1:0];
        end
    end

    always_comb begin
        result = '0;
        case (alu_control)
            ALU_AND:  result = src_a & src_b;
            ALU_OR:   result = src_a | src_b;
            ALU_ADD:  result = src_a + src_b;
            ALU_SUB:  result = src_a - src_b;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_LUI:  result = {src_b[15:0], 16'h0};
            ALU_MFHI: result = hi_reg;
            ALU_MFLO: result = lo_reg;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);
    // The instruction retires in DONE, so the stall lifts for that cycle.
    assign stall = ~reset & valid & is_md & ~md_done;

endmodule
